// File: rtl/serial_tx_8b.sv
// Parallel-to-serial byte transmitter on clk8f, MSB first, with an idle-symbol sync preamble after reset.
// Optional feature macro: SERIAL_TX_UNDERRUN_CNT_EN adds the underrun_cnt output.
module serial_tx_8b #(
  parameter logic [7:0] IDLE_SYM   = 8'hBC,
  parameter int         SYNC_COUNT = 4
) (
  input  logic       clk8f,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       in_ready,
  output logic       data_out,
  output logic       active
`ifdef SERIAL_TX_UNDERRUN_CNT_EN
  ,
  output logic [7:0] underrun_cnt
`endif
);
  typedef enum logic {SYNC = 1'b0, ACTIVE = 1'b1} state_t;

  localparam logic [7:0] SYNC_LAST = 8'(SYNC_COUNT - 1);

  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic [7:0] sym_cnt;
  state_t     state;
  logic       reload;

  assign reload   = (bit_cnt == 3'd7);
  // The last preamble reload already opens the capture window.
  assign in_ready = reload && ((state == ACTIVE) || (state == SYNC && sym_cnt == SYNC_LAST));
  assign data_out = shreg[7];
  assign active   = (state == ACTIVE);

  always_ff @(posedge clk8f or posedge reset) begin
    if (reset) begin
      bit_cnt <= '0;
      shreg   <= IDLE_SYM;
      sym_cnt <= '0;
      state   <= SYNC;
    end else begin
      bit_cnt <= bit_cnt + 3'd1;
      if (!reload) begin
        shreg <= {shreg[6:0], 1'b0};
      end else begin
        shreg <= (in_ready && valid_in) ? data_in : IDLE_SYM;
        if (state == SYNC) begin
          sym_cnt <= sym_cnt + 8'd1;
          if (sym_cnt == SYNC_LAST) state <= ACTIVE;
        end
      end
    end
  end

`ifdef SERIAL_TX_UNDERRUN_CNT_EN
  // Only gaps in ACTIVE count; preamble idles are expected, not underruns.
  always_ff @(posedge clk8f or posedge reset) begin
    if (reset) begin
      underrun_cnt <= '0;
    end else if (reload && state == ACTIVE && !valid_in && underrun_cnt != 8'hFF) begin
      underrun_cnt <= underrun_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_serial_tx_8b.sv
// Scoreboard bench for serial_tx_8b: stimulus pushes expected per-cycle line state, monitors pop and compare.
module tb_serial_tx_8b;
  typedef struct packed { logic d; logic rdy; logic act; } exp_t;

  localparam logic [7:0] IDLE0 = 8'hBC;
  localparam logic [7:0] IDLE1 = 8'h7C;

  logic       clk8f;
  logic       reset, rst1;
  logic [7:0] data_in, d1;
  logic       valid_in, v1;
  logic       in_ready, data_out, active;
  logic       rdy1, dout1, act1;
`ifdef SERIAL_TX_UNDERRUN_CNT_EN
  logic [7:0] ucnt, ucnt1;
`endif

  exp_t q0[$];
  exp_t q1[$];
  logic mon0, mon1;
  int   checks, errors;
  logic act_phase;
  int   exp_ur;

  serial_tx_8b u_dut (
    .clk8f(clk8f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .in_ready(in_ready), .data_out(data_out), .active(active)
`ifdef SERIAL_TX_UNDERRUN_CNT_EN
    , .underrun_cnt(ucnt)
`endif
  );

  serial_tx_8b #(.IDLE_SYM(8'h7C), .SYNC_COUNT(1)) u_dut1 (
    .clk8f(clk8f), .reset(rst1), .data_in(d1), .valid_in(v1),
    .in_ready(rdy1), .data_out(dout1), .active(act1)
`ifdef SERIAL_TX_UNDERRUN_CNT_EN
    , .underrun_cnt(ucnt1)
`endif
  );

  initial clk8f = 1'b0;
  always #5 clk8f = ~clk8f;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic d, input logic r, input logic a);
    exp_t e;
    e.d = d; e.rdy = r; e.act = a;
    return e;
  endfunction

  always @(negedge clk8f) begin
    exp_t e;
    if (mon0 && q0.size() > 0) begin
      e = q0.pop_front();
      chk("dut0.data_out", {31'd0, data_out}, {31'd0, e.d});
      chk("dut0.in_ready", {31'd0, in_ready}, {31'd0, e.rdy});
      chk("dut0.active",   {31'd0, active},   {31'd0, e.act});
    end
  end

  always @(negedge clk8f) begin
    exp_t e;
    if (mon1 && q1.size() > 0) begin
      e = q1.pop_front();
      chk("dut1.data_out", {31'd0, dout1}, {31'd0, e.d});
      chk("dut1.in_ready", {31'd0, rdy1},  {31'd0, e.rdy});
      chk("dut1.active",   {31'd0, act1},  {31'd0, e.act});
    end
  end

  // Reset, then release; the 32 preamble cycles are always IDLE with in_ready only in cycle 32.
  task automatic do_reset(input logic v, input logic [7:0] d);
    logic [7:0] idle;
    idle = IDLE0;
    mon0 = 1'b0;
    q0.delete();
    reset = 1'b1;
    valid_in = v;
    data_in = d;
    act_phase = 1'b0;
    exp_ur = 0;
    repeat (2) @(posedge clk8f);
    #1 reset = 1'b0;
    for (int c = 1; c <= 32; c++)
      q0.push_back(mk(idle[7 - ((c - 1) % 8)], c == 32, 1'b0));
    mon0 = 1'b1;
  endtask

  // Drive one 8-cycle slot; the symbol captured at its end is transmitted in the following slot.
  task automatic run_slot(input logic v, input logic [7:0] d, input int pulse, input logic [7:0] nxt);
    logic gap;
    data_in = d;
    for (int i = 0; i < 8; i++) begin
      valid_in = (pulse < 0) ? v : (i == pulse);
      @(posedge clk8f);
      #1;
    end
    gap = (pulse < 0) ? !v : (pulse != 7);
    if (act_phase && gap && exp_ur < 255) exp_ur++;
    act_phase = 1'b1;
    for (int j = 0; j < 8; j++)
      q0.push_back(mk(nxt[7 - j], j == 7, 1'b1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] i1, s1;
    checks = 0; errors = 0;
    mon0 = 1'b0; mon1 = 1'b0;
    reset = 1'b1; rst1 = 1'b1;
    valid_in = 1'b0; data_in = 8'h00;
    v1 = 1'b1; d1 = 8'h5A;
    act_phase = 1'b0; exp_ur = 0;
    repeat (2) @(posedge clk8f);
    #1;
    chk("reset.data_out", {31'd0, data_out}, 32'd1);
    chk("reset.in_ready", {31'd0, in_ready}, 32'd0);
    chk("reset.active",   {31'd0, active},   32'd0);
`ifdef SERIAL_TX_UNDERRUN_CNT_EN
    chk("reset.underrun_cnt", {24'd0, ucnt}, 32'd0);
`endif

    // IDLE_SYM=7C, SYNC_COUNT=1, valid held with 5A: one 7C symbol then 5A repeating
    i1 = IDLE1; s1 = 8'h5A;
    rst1 = 1'b0;
    for (int c = 1; c <= 8; c++) q1.push_back(mk(i1[8 - c], c == 8, 1'b0));
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 8; j++) q1.push_back(mk(s1[7 - j], j == 7, 1'b1));
    mon1 = 1'b1;
    repeat (32) @(posedge clk8f);
    #1;
    mon1 = 1'b0;
    rst1 = 1'b1;
    chk("dut1.drain", q1.size(), 32'd0);

    // Preamble with no data, then one underrun slot
    do_reset(1'b0, 8'h00);
    repeat (24) @(posedge clk8f);
    #1;
    run_slot(1'b0, 8'h00, -1, 8'hBC);
    run_slot(1'b0, 8'h00, -1, 8'hBC);
    // Alternating data and gaps: 3C,BC,3C,BC
    run_slot(1'b1, 8'h3C, -1, 8'h3C);
    run_slot(1'b0, 8'h3C, -1, 8'hBC);
    run_slot(1'b1, 8'h3C, -1, 8'h3C);
    run_slot(1'b0, 8'h3C, -1, 8'hBC);
    // valid pulsed while bit_cnt=3 is ignored
    run_slot(1'b1, 8'hFF, 3, 8'hBC);
`ifdef SERIAL_TX_UNDERRUN_CNT_EN
    chk("underrun_cnt.alt", {24'd0, ucnt}, exp_ur);
`endif

    // A5 held valid from reset: BC preamble, then A5 every slot
    do_reset(1'b1, 8'hA5);
    repeat (24) @(posedge clk8f);
    #1;
    run_slot(1'b1, 8'hA5, -1, 8'hA5);
    run_slot(1'b1, 8'hA5, -1, 8'hA5);
    run_slot(1'b1, 8'hA5, -1, 8'hA5);

    // Reset asserted mid-symbol while 0F is on the line
    run_slot(1'b1, 8'h0F, -1, 8'h0F);
    valid_in = 1'b0;
    @(posedge clk8f);
    @(posedge clk8f);
    #1;
    chk("mid.data_out_before", {31'd0, data_out}, 32'd0);
    mon0 = 1'b0;
    reset = 1'b1;
    #1;
    chk("mid.data_out_async", {31'd0, data_out}, 32'd1);
    chk("mid.active_async",   {31'd0, active},   32'd0);
    chk("mid.in_ready_async", {31'd0, in_ready}, 32'd0);
    do_reset(1'b0, 8'h00);
`ifdef SERIAL_TX_UNDERRUN_CNT_EN
    chk("underrun_cnt.after_reset", {24'd0, ucnt}, 32'd0);
`endif
    repeat (24) @(posedge clk8f);
    #1;
    run_slot(1'b1, 8'h0F, -1, 8'h0F);
    run_slot(1'b0, 8'h00, -1, 8'hBC);

`ifdef SERIAL_TX_UNDERRUN_CNT_EN
    for (int k = 0; k < 300; k++) run_slot(1'b0, 8'h00, -1, 8'hBC);
    chk("underrun_cnt.sat", {24'd0, ucnt}, 32'd255);
`endif

    repeat (8) @(posedge clk8f);
    #1;
    chk("dut0.drain", q0.size(), 32'd0);
    mon0 = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
